// File: rtl/mod_reduce.sv
// mod_reduce: bit-serial reduction of a 2N-bit product modulo an N-bit M.
// One conditional subtract per product bit, MSB first; 2N cycles per result.
module mod_reduce #(
  parameter int N = 256
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   M,
  output logic [N-1:0]   R,
  output logic           done,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(2*N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_d;
  logic [2*N-1:0] pcap, pcap_d;
  logic [N-1:0]   mcap, mcap_d;
  logic [N-1:0]   rem, rem_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [N-1:0]   r_d;
  logic           done_d, busy_d, err_d;

  logic [N:0]     t;
  logic           t_ge;
  logic [N-1:0]   rem_step;

  // pcap shifts left each step, so its MSB is the bit at index cnt
  assign t        = {rem, pcap[2*N-1]};
  assign t_ge     = t >= {1'b0, mcap};
  assign rem_step = t_ge ? N'(t - {1'b0, mcap}) : t[N-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pcap  <= '0;
      mcap  <= '0;
      rem   <= '0;
      cnt   <= '0;
      R     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      pcap  <= pcap_d;
      mcap  <= mcap_d;
      rem   <= rem_d;
      cnt   <= cnt_d;
      R     <= r_d;
      done  <= done_d;
      busy  <= busy_d;
      err   <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start && M != '0) state_d = RUN;
      RUN:  if (cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pcap_d = pcap;
    mcap_d = mcap;
    rem_d  = rem;
    cnt_d  = cnt;
    r_d    = R;
    done_d = 1'b0;
    busy_d = busy;
    err_d  = err;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (M == '0) begin
            r_d    = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            pcap_d = P;
            mcap_d = M;
            rem_d  = '0;
            cnt_d  = CW'(2*N-1);
            busy_d = 1'b1;
            err_d  = 1'b0;
          end
        end
      end
      RUN: begin
        rem_d  = rem_step;
        pcap_d = pcap << 1;
        if (cnt == '0) begin
          cnt_d  = '0;
          r_d    = rem_step;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mod_reduce.sv
// tb_mod_reduce: directed vectors for mod_reduce at N=256.
// Hand-computed residues; latency, pulse, reset and ignore behaviour.
module tb_mod_reduce;

  localparam int N = 256;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [2*N-1:0] P = '0;
  logic [N-1:0]   M = '0;
  logic [N-1:0]   R;
  logic           done, busy, err;

  int total  = 0;
  int passed = 0;
  int lat, bcyc;

  logic [2*N-1:0] a, sq;
  logic [2*N-1:0] p_ones, p_msb;
  logic [N-1:0]   m_ones;

  mod_reduce #(.N(N)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .P(P),
    .M(M),
    .R(R),
    .done(done),
    .busy(busy),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [2*N-1:0] obs,
                     input logic [2*N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // caller sits just after an edge; operands are scrambled after acceptance
  task automatic accept(input logic [2*N-1:0] p, input logic [N-1:0] m);
    P     = p;
    M     = m;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    P     = {16{$urandom}};
    M     = {8{$urandom}};
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (!done && l < 600) begin
      if (busy) b++;
      tick(1);
      l++;
    end
  endtask

  initial begin
    a      = {256'b0, {255{1'b1}}, 1'b0};
    sq     = a * a;
    p_ones = '1;
    p_msb  = '0;
    p_msb[2*N-1] = 1'b1;
    m_ones = '1;

    tick(3);
    chk("rst_R", R, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;

    accept(100, 7);
    chk("t1_busy", busy, 1);
    wait_done(lat, bcyc);
    chk("t1_lat", lat, 512);
    chk("t1_busy_cycles", bcyc, 512);
    chk("t1_R", R, 2);
    chk("t1_err", err, 0);
    chk("t1_busy_end", busy, 0);
    tick(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_R_hold", R, 2);

    accept(p_ones, m_ones);
    wait_done(lat, bcyc);
    chk("t2_lat", lat, 512);
    chk("t2_R", R, 0);

    accept(p_msb, 3);
    wait_done(lat, bcyc);
    chk("t3a_lat", lat, 512);
    chk("t3a_R", R, 2);
    accept(sq, m_ones);
    chk("t3b_busy", busy, 1);
    chk("t3b_done_low", done, 0);
    wait_done(lat, bcyc);
    chk("t3b_lat", lat, 512);
    chk("t3b_R", R, 1);
    tick(1);

    accept(512'h1234_5678_9abc_def0_1357_9bdf, 1);
    wait_done(lat, bcyc);
    chk("t4_m1_R", R, 0);
    accept(5, 1000);
    wait_done(lat, bcyc);
    chk("t4_pltm_R", R, 5);
    tick(1);

    accept(5, 0);
    chk("t5_done", done, 1);
    chk("t5_err", err, 1);
    chk("t5_R", R, 0);
    chk("t5_busy", busy, 0);
    tick(1);
    chk("t5_done_clr", done, 0);
    chk("t5_err_hold", err, 1);
    chk("t5_busy_idle", busy, 0);
    accept(10, 3);
    chk("t5_err_clr", err, 0);
    chk("t5b_busy", busy, 1);
    wait_done(lat, bcyc);
    chk("t5b_lat", lat, 512);
    chk("t5b_R", R, 1);
    tick(1);

    accept(1000003, 97);
    tick(100);
    chk("t6_R_hold", R, 1);
    P     = 777;
    M     = 5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(lat, bcyc);
    chk("t6_lat", lat, 411);
    chk("t6_R", R, 30);
    tick(1);

    accept(12345, 1000);
    tick(200);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t7_R", R, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    wait_done(lat, bcyc);
    chk("t7_no_done", lat, 600);
    accept(10, 3);
    wait_done(lat, bcyc);
    chk("t7b_lat", lat, 512);
    chk("t7b_R", R, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
